// File: rtl/uc_multiciclo.sv
// Multicycle control unit: sequences each instruction through FETCH, DECODE and EXEC.
// Define WAIT_STATE_EN to make FETCH wait for mem_ready from instruction memory.
module uc_multiciclo (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        z,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        ir_load,
  output logic        we_pc,
  output logic        s_inc,
  output logic        s_inm,
  output logic        we3,
  output logic        wez,
  output logic [2:0]  op_alu,
  output logic        halted,
  output logic [15:0] instr_count,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    ST_RST    = 3'b000,
    ST_FETCH  = 3'b001,
    ST_DECODE = 3'b010,
    ST_EXEC   = 3'b011,
    ST_HALT   = 3'b100
  } state_t;

  localparam logic [5:0] OP_JMP  = 6'b110000;
  localparam logic [5:0] OP_JZ   = 6'b110001;
  localparam logic [5:0] OP_JNZ  = 6'b110010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  state_t      state, state_next;
  logic        z_q;
  logic        take;
  logic        fetch_done;
  logic [15:0] count_q;

`ifdef WAIT_STATE_EN
  assign fetch_done = mem_ready;
`else
  assign fetch_done = 1'b1;
`endif

  // z_q is captured in DECODE and the opcode is held stable through EXEC, so
  // this decode of the two is the branch decision registered at DECODE.
  always_comb begin
    case (opcode)
      OP_JMP:  take = 1'b1;
      OP_JZ:   take = z_q;
      OP_JNZ:  take = ~z_q;
      default: take = 1'b0;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    ir_load    = 1'b0;
    we_pc      = 1'b0;
    s_inc      = 1'b1;
    s_inm      = 1'b0;
    we3        = 1'b0;
    wez        = 1'b0;
    op_alu     = 3'b000;
    halted     = 1'b0;

    case (state)
      ST_RST: state_next = ST_FETCH;

      ST_FETCH: begin
        mem_req = 1'b1;
        if (fetch_done) begin
          ir_load    = 1'b1;
          state_next = ST_DECODE;
        end
      end

      ST_DECODE: state_next = (opcode == OP_HALT) ? ST_HALT : ST_EXEC;

      ST_EXEC: begin
        we_pc      = 1'b1;
        state_next = ST_FETCH;
        if (!opcode[5]) begin
          op_alu = opcode[4:2];
          we3    = 1'b1;
          wez    = 1'b1;
        end else if (opcode[5:4] == 2'b10) begin
          we3   = 1'b1;
          s_inm = 1'b1;
        end else if (opcode == OP_JMP || opcode == OP_JZ || opcode == OP_JNZ) begin
          s_inc = ~take;
        end
      end

      ST_HALT: halted = 1'b1;

      default: state_next = ST_RST;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_RST;
      z_q     <= 1'b0;
      count_q <= 16'h0000;
    end else begin
      state <= state_next;
      if (state == ST_DECODE) z_q <= z;
      if (state == ST_EXEC) count_q <= count_q + 16'h0001;
    end
  end

  assign instr_count = count_q;
  assign state_dbg   = state;

endmodule

// File: doc/uc_multiciclo.md
# uc_multiciclo

Multicycle control unit for the CPU datapath. It sequences each instruction through fetch, decode and execute states instead of decoding in one cycle. It handshakes with instruction memory, gates the register-file, zero-flag and PC write enables to a single execute cycle, and handles a halt instruction. It sits between the instruction register (IR) / zero-flag outputs and the datapath control inputs, and drives the same control signals as the single-cycle unit plus the sequencing strobes.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 forces state RST
- opcode  in  6  IR[15:10]; stable from the cycle after ir_load until the next ir_load
- z  in  1  zero flag from the datapath flag register
- mem_ready  in  1  instruction memory has valid data this cycle (used only with WAIT_STATE_EN)
- mem_req  out  1  instruction fetch request
- ir_load  out  1  load IR from instruction memory this cycle
- we_pc  out  1  PC write enable; the PC updates on this edge
- s_inc  out  1  PC mux select: 1 = PC+1, 0 = jump target
- s_inm  out  1  register-file write-data mux: 1 = immediate, 0 = ALU
- we3  out  1  register-file write enable
- wez  out  1  zero-flag register write enable
- op_alu  out  3  ALU operation
- halted  out  1  1 while in HALT
- instr_count  out  16  count of retired instructions
- state_dbg  out  3  current state encoding

## Operation
- States and encodings: RST=000, FETCH=001, DECODE=010, EXEC=011, HALT=100.
- RST: all strobes are 0. Next state is FETCH, entered one cycle after reset deasserts.
- FETCH: mem_req=1. On the cycle the fetch completes, ir_load=1 and the next state is DECODE. Otherwise the unit stays in FETCH with mem_req held at 1.
- DECODE:
  - Registers z into z_q.
  - Registers the branch decision:
    - take = 1 for 110000
    - take = z for 110001
    - take = ~z for 110010
    - take = 0 otherwise.
  - opcode 111111 -> next state HALT. Otherwise -> EXEC.
- EXEC: we_pc=1. The remaining strobes depend on the opcode class:
  - 0xxxxx (ALU): op_alu=opcode[4:2], we3=1, wez=1, s_inm=0, s_inc=1.
  - 10xxxx (load immediate): we3=1, s_inm=1, s_inc=1, wez=0.
  - 110000/110001/110010 (jumps): s_inc=~take, we3=0, wez=0.
  - Any other opcode (not 111111): NOP. s_inc=1, no writes.
  - instr_count increments. Next state is FETCH.
- HALT: all strobes 0 and halted=1. The unit stays in HALT until reset.
- Default values outside EXEC: we3=0, wez=0, we_pc=0, s_inm=0, s_inc=1, op_alu=000. These are also the values during reset.
- The strobes are combinational in state, opcode and the take register. No strobe depends combinationally on z; only z_q/take are used.
- instr_count is a 16-bit counter that wraps from 0xFFFF to 0x0000. It does not increment for the HALT instruction.

## Timing
- Latency without wait states: 3 cycles per instruction (FETCH, DECODE, EXEC). Each low-mem_ready cycle in FETCH adds one cycle.
- The flag written by an ALU instruction in its EXEC cycle is visible to a following conditional jump, because that jump samples z in its DECODE cycle, 2 cycles later.
- Reset asserted in any state: outputs go to their reset values immediately (asynchronously). instr_count=0, take=0, z_q=0, and the state is RST. The first FETCH occurs in the cycle after the first rising edge with reset=1.
- mem_ready high while not in FETCH is ignored.

## Configuration
- WAIT_STATE_EN defined: a fetch completes only on a cycle with mem_ready=1. FETCH may last any number of cycles.
- WAIT_STATE_EN undefined: mem_ready is ignored and FETCH always lasts exactly 1 cycle.

## Test plan
- Reset and start: hold reset=0 for 3 cycles, then release. Required response:
  - state_dbg = 000, then 001 one cycle after release.
  - All write enables 0 throughout.
  - instr_count = 0.
- ALU instruction: opcode 001100, mem_ready=1. Required response:
  - Exactly one EXEC cycle with op_alu=011, we3=1, wez=1, we_pc=1, s_inc=1.
  - Instruction retires in 3 cycles; instr_count becomes 1.
- Conditional jumps:
  - 110001 with z=1 at DECODE -> EXEC has s_inc=0, we_pc=1.
  - Same opcode with z=0 -> s_inc=1.
  - 110010 gives the inverse results.
- Wait states (WAIT_STATE_EN): hold mem_ready=0 for 4 cycles in FETCH. Required response:
  - mem_req stays 1 and ir_load stays 0 during those cycles.
  - ir_load pulses on the first mem_ready=1 cycle.
  - The instruction takes 7 cycles in total.
- Halt and reset mid-operation:
  - opcode 111111 -> halted=1 and state_dbg=100 from the cycle after DECODE. No further strobes; instr_count unchanged.
  - Asserting reset in EXEC clears we3/we_pc immediately and sets instr_count=0.
- Counter wrap: preload via 65535 retired NOPs (opcode 111000). The next instruction makes instr_count 0x0000.
